// File: rtl/video_pkg.sv
// Shared video definitions for the frame capture path.
// Holds the default frame geometry and pixel width used by the decoder and
// its downstream consumers, plus the capture controller state type.
package video_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int FRAME_W_DEF = 64;
    localparam int FRAME_H_DEF = 48;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } fcb_state_t;

endpackage

// File: rtl/frame_capture_buffer_if.sv
// Pixel-in / pixel-out stream bundle for the frame capture buffer.
//   pix_data, pix_valid, pix_sof : decoded pixel stream into the buffer
//   out_data, out_valid, out_last: stored frame streamed out of the buffer
//   out_ready                    : consumer back-pressure
// slave  : the frame capture buffer side
// master : the surrounding system (decoder feed + vision consumer)
interface frame_capture_buffer_if
    import video_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  pix_data, pix_valid, pix_sof, out_ready,
        output out_data, out_valid, out_last
    );

    modport master (
        output pix_data, pix_valid, pix_sof, out_ready,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store, DEPTH x PIX_W.
//   clk              : clock
//   wr_en/addr/data  : synchronous write port
//   rd_en/addr       : synchronous read request
//   rd_data          : read result one cycle after rd_en; holds when rd_en is low
// Storage has no reset so it maps onto block RAM.
module frame_buffer_ram #(
    parameter int DEPTH  = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/frame_capture_buffer.sv
// Single-frame capture buffer between the video decoder and the vision stage.
// On a trigger it waits for the next start of frame, stores one full frame,
// then streams it out in raster order over valid/ready.
//   clk, reset        : clock, async active-low reset
//   vid               : pixel stream in, frame stream out (slave modport)
//   capture_trigger   : one-cycle capture request
//   busy              : high whenever not IDLE
//   capture_done      : pulse after the last pixel is written
//   short_frame       : pulse when an early sof restarts the capture
//   trigger_dropped   : pulse when a trigger arrives while busy
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for capture_trigger
// ARMED   | waiting for the next start-of-frame pixel
// CAPTURE | writing pixels at wr_cnt until DEPTH-1 is written
// READOUT | streaming the stored frame, index rd_cnt on the output
module frame_capture_buffer
    import video_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int PIX_W   = PIX_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_capture_buffer_if.slave vid,
    input  logic                  capture_trigger,
    output logic                  busy,
    output logic                  capture_done,
    output logic                  short_frame,
    output logic                  trigger_dropped
);
    localparam int DEPTH  = FRAME_W * FRAME_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    fcb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [ADDR_W-1:0] rd_cnt, rd_cnt_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic              done_nxt, short_nxt, drop_nxt;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    frame_buffer_ram #(
        .DEPTH  (DEPTH),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (vid.pix_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The RAM read register doubles as the output register: it is only
    // reloaded on a handshake, so it holds the presented pixel during stalls.
    // Gating with out_valid keeps out_data at 0 in reset and when idle.
    assign vid.out_data  = out_valid_q ? rd_data : '0;
    assign vid.out_valid = out_valid_q;
    assign vid.out_last  = out_valid_q && (rd_cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            out_valid_q     <= 1'b0;
            busy            <= 1'b0;
            capture_done    <= 1'b0;
            short_frame     <= 1'b0;
            trigger_dropped <= 1'b0;
        end else begin
            state           <= state_nxt;
            wr_cnt          <= wr_cnt_nxt;
            rd_cnt          <= rd_cnt_nxt;
            out_valid_q     <= out_valid_nxt;
            busy            <= (state_nxt != IDLE);
            capture_done    <= done_nxt;
            short_frame     <= short_nxt;
            trigger_dropped <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_cnt_nxt    = wr_cnt;
        rd_cnt_nxt    = rd_cnt;
        out_valid_nxt = out_valid_q;
        done_nxt      = 1'b0;
        short_nxt     = 1'b0;
        drop_nxt      = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = wr_cnt;
        rd_en         = 1'b0;
        rd_addr       = rd_cnt;

        case (state)
            IDLE: begin
                if (capture_trigger) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                drop_nxt = capture_trigger;
                if (vid.pix_valid && vid.pix_sof) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_cnt_nxt = ONE;
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: begin
                drop_nxt = capture_trigger;
                if (vid.pix_valid) begin
                    wr_en = 1'b1;
                    if (vid.pix_sof) begin
                        // Early sof: restart the frame from this pixel.
                        wr_addr    = '0;
                        wr_cnt_nxt = ONE;
                        short_nxt  = 1'b1;
                    end else if (wr_cnt == LAST_ADDR) begin
                        wr_cnt_nxt = '0;
                        done_nxt   = 1'b1;
                        state_nxt  = READOUT;
                    end else begin
                        wr_cnt_nxt = wr_cnt + ONE;
                    end
                end
            end
            READOUT: begin
                drop_nxt = capture_trigger;
                if (!out_valid_q) begin
                    // First cycle in READOUT: prefetch pixel 0.
                    rd_en         = 1'b1;
                    rd_addr       = rd_cnt;
                    out_valid_nxt = 1'b1;
                end else if (vid.out_ready) begin
                    if (rd_cnt == LAST_ADDR) begin
                        out_valid_nxt = 1'b0;
                        rd_cnt_nxt    = '0;
                        state_nxt     = IDLE;
                    end else begin
                        rd_en      = 1'b1;
                        rd_addr    = rd_cnt + ONE;
                        rd_cnt_nxt = rd_cnt + ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_frame_capture_buffer.sv
// Self-checking bench for frame_capture_buffer with a 4x2 frame.
// A queue-based reference model tracks what the buffer must hold and emit,
// and one compare process checks the outputs on every falling edge.
module tb_frame_capture_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic trig = 1'b0;
    logic busy, capture_done, short_frame, trigger_dropped;

    frame_capture_buffer_if #(.PIX_W(8)) vif();

    frame_capture_buffer #(
        .FRAME_W (4),
        .FRAME_H (2),
        .PIX_W   (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .vid             (vif),
        .capture_trigger (trig),
        .busy            (busy),
        .capture_done    (capture_done),
        .short_frame     (short_frame),
        .trigger_dropped (trigger_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    // Reference model: 0 idle, 1 waiting for sof, 2 collecting, 3 emitting
    int         m_mode = 0;
    logic [7:0] cap_q[$];
    logic [7:0] frame_q[$];
    bit         e_busy, e_done, e_short, e_drop;
    int         rd_wait;
    bit         seen_valid;

    logic [7:0] got_q[$];
    int         n_done, n_short, n_drop, n_last;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            m_mode = 0;
            cap_q.delete();
            frame_q.delete();
            e_busy = 0; e_done = 0; e_short = 0; e_drop = 0;
            check("rst_busy", busy, 0);
            check("rst_out_valid", vif.out_valid, 0);
            check("rst_out_data", vif.out_data, 0);
        end else begin
            check("busy", busy, e_busy);
            check("capture_done", capture_done, e_done);
            check("short_frame", short_frame, e_short);
            check("trigger_dropped", trigger_dropped, e_drop);
            if (capture_done)    n_done++;
            if (short_frame)     n_short++;
            if (trigger_dropped) n_drop++;

            if (m_mode != 3) begin
                check("out_valid_quiet", vif.out_valid, 0);
            end else begin
                rd_wait++;
                if (vif.out_valid) seen_valid = 1;
                if (seen_valid || rd_wait >= 3) check("out_valid_readout", vif.out_valid, 1);
                if (vif.out_valid && frame_q.size() > 0) begin
                    check("out_data", vif.out_data, frame_q[0]);
                    check("out_last", vif.out_last, frame_q.size() == 1);
                end
            end

            e_done = 0; e_short = 0; e_drop = 0;
            case (m_mode)
                0: if (trig) m_mode = 1;
                1: begin
                    e_drop = trig;
                    if (vif.pix_valid && vif.pix_sof) begin
                        cap_q.delete();
                        cap_q.push_back(vif.pix_data);
                        m_mode = 2;
                    end
                end
                2: begin
                    e_drop = trig;
                    if (vif.pix_valid) begin
                        if (vif.pix_sof) begin
                            cap_q.delete();
                            cap_q.push_back(vif.pix_data);
                            e_short = 1;
                        end else begin
                            cap_q.push_back(vif.pix_data);
                            if (cap_q.size() == DEPTH) begin
                                frame_q = cap_q;
                                e_done = 1;
                                rd_wait = 0;
                                seen_valid = 0;
                                m_mode = 3;
                            end
                        end
                    end
                end
                default: begin
                    e_drop = trig;
                    if (vif.out_valid && vif.out_ready) begin
                        got_q.push_back(vif.out_data);
                        if (vif.out_last) n_last++;
                        if (frame_q.size() > 0) void'(frame_q.pop_front());
                        if (frame_q.size() == 0) m_mode = 0;
                    end
                end
            endcase
            e_busy = (m_mode != 0);
        end
    end

    // Consumer: 0 always ready, 1 pattern 1,0,0 repeating, 2 random
    int ph = 2;
    initial begin
        vif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: vif.out_ready = 1'b1;
                1: begin
                    ph = (ph + 1) % 3;
                    vif.out_ready = (ph == 0);
                end
                default: vif.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        cyc();
        trig = 1'b0;
    endtask

    task automatic send_px(logic [7:0] d, bit sof, bit with_trig);
        vif.pix_valid = 1'b1;
        vif.pix_data  = d;
        vif.pix_sof   = sof;
        trig          = with_trig;
        cyc();
        vif.pix_valid = 1'b0;
        vif.pix_sof   = 1'b0;
        trig          = 1'b0;
    endtask

    task automatic send_frame(logic [7:0] base, int gap_max);
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, gap_max)) cyc();
            send_px(8'(base + i), i == 0, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            cyc();
            k++;
        end
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b required 0 after %0d cycles", busy, k);
        end
        cyc();
    endtask

    task automatic clr();
        got_q.delete();
        n_done = 0; n_short = 0; n_drop = 0; n_last = 0;
    endtask

    task automatic expect_frame(string name, logic [7:0] base);
        check({name, "_count"}, got_q.size(), DEPTH);
        for (int i = 0; i < got_q.size() && i < DEPTH; i++)
            check(name, got_q[i], 8'(base + i));
        check({name, "_last_cnt"}, n_last, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.pix_valid = 1'b0;
        vif.pix_sof   = 1'b0;
        vif.pix_data  = 8'h00;
        repeat (3) cyc();
        check("init_busy", busy, 0);
        check("init_out_valid", vif.out_valid, 0);
        check("init_out_last", vif.out_last, 0);
        check("init_pulses", {capture_done, short_frame, trigger_dropped}, 0);
        reset = 1'b1;
        cyc();

        // Basic capture
        clr();
        rdy_mode = 0;
        pulse_trig();
        cyc();
        send_frame(8'h10, 0);
        wait_idle();
        expect_frame("basic", 8'h10);
        check("basic_done_cnt", n_done, 1);

        // Backpressure
        clr();
        rdy_mode = 1;
        pulse_trig();
        cyc();
        send_frame(8'h50, 0);
        wait_idle();
        expect_frame("backpressure", 8'h50);

        // Trigger mid-frame, tail ignored, next frame with gaps
        clr();
        rdy_mode = 0;
        send_px(8'h60, 1'b1, 1'b0);
        send_px(8'h61, 1'b0, 1'b0);
        send_px(8'h62, 1'b0, 1'b1);
        for (int i = 3; i < DEPTH; i++) send_px(8'(8'h60 + i), 1'b0, 1'b0);
        send_frame(8'h20, 3);
        wait_idle();
        expect_frame("arm_gap", 8'h20);

        // Short frame
        clr();
        pulse_trig();
        for (int i = 0; i < 4; i++) send_px(8'(8'h30 + i), i == 0, 1'b0);
        send_frame(8'h40, 0);
        wait_idle();
        expect_frame("short", 8'h40);
        check("short_cnt", n_short, 1);

        // Triggers during capture and readout are dropped
        clr();
        rdy_mode = 1;
        pulse_trig();
        for (int i = 0; i < DEPTH; i++) send_px(8'(8'h70 + i), i == 0, i == 4);
        repeat (3) cyc();
        pulse_trig();
        wait_idle();
        expect_frame("dropped", 8'h70);
        check("dropped_cnt", n_drop, 2);

        // Trigger together with sof in IDLE skips that frame
        clr();
        rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) send_px(8'(8'h80 + i), i == 0, i == 0);
        send_frame(8'h90, 1);
        wait_idle();
        expect_frame("trig_sof", 8'h90);

        // Reset during readout
        clr();
        pulse_trig();
        send_frame(8'hA0, 0);
        begin
            int k = 0;
            while (got_q.size() < 3 && k < 100) begin
                cyc();
                k++;
            end
            check("rst_mid_reached", got_q.size() >= 3, 1);
        end
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_out_valid", vif.out_valid, 0);
        check("rst_mid_out_data", vif.out_data, 0);
        check("rst_mid_out_last", vif.out_last, 0);
        check("rst_mid_pulses", {capture_done, short_frame, trigger_dropped}, 0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        clr();
        pulse_trig();
        send_frame(8'hB0, 1);
        wait_idle();
        expect_frame("after_reset", 8'hB0);

        // Randomized frames, gaps, back-pressure and stray triggers
        rdy_mode = 2;
        for (int f = 0; f < 6; f++) begin
            clr();
            pulse_trig();
            repeat ($urandom_range(0, 3)) send_px(8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                repeat ($urandom_range(0, 2)) cyc();
                send_px(8'($urandom), i == 0, ($urandom_range(0, 7) == 0));
            end
            if ($urandom_range(0, 1) == 1) pulse_trig();
            wait_idle();
            check("rand_count", got_q.size(), DEPTH);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
